// File: rtl/word_fetch_pkg.sv
// Shared definitions for the 16-bit little-endian word fetch engine.
package word_fetch_pkg;

  // Fetch FSM state encoding, shared with the control unit and benches.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReadLo = 2'd1,
    StReadHi = 2'd2,
    StDone   = 2'd3
  } fetch_state_e;

  // Address of the high byte. With page_wrap set, the carry out of the low
  // address byte is dropped, mimicking the 6502 indirect-vector quirk.
  function automatic logic [15:0] hi_addr(input logic [15:0] base, input logic page_wrap);
    logic [15:0] addr;
    if (page_wrap) begin
      addr = {base[15:8], base[7:0] + 8'd1};
    end else begin
      addr = base + 16'd1;
    end
    return addr;
  endfunction

endpackage

// File: rtl/word_fetch.sv
// Fetches a 16-bit little-endian word from byte-wide memory, low byte first,
// with an open-ended mem_ready handshake on each byte.
module word_fetch
  import word_fetch_pkg::*;
#(
  parameter int unsigned PAGE_WRAP = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] base_addr,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  input  logic        mem_ready,
  output logic [15:0] word_out,
  output logic        busy,
  output logic        done
);

  localparam logic PageWrapEn = (PAGE_WRAP != 0);

  fetch_state_e state_q, state_d;
  logic [15:0]  addr_q;
  logic [15:0]  word_q;

  // State, captured base address and assembled word; reset clears all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= 16'h0000;
      word_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        addr_q <= base_addr;
      end
      if (state_q == StReadLo && mem_ready) begin
        word_q[7:0] <= mem_data;
      end
      if (state_q == StReadHi && mem_ready) begin
        word_q[15:8] <= mem_data;
      end
    end
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    state_d  = state_q;
    mem_rd   = 1'b0;
    mem_addr = 16'h0000;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StReadLo;
      end
      StReadLo: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q;
        busy     = 1'b1;
        if (mem_ready) state_d = StReadHi;
      end
      StReadHi: begin
        mem_rd   = 1'b1;
        mem_addr = hi_addr(addr_q, PageWrapEn);
        busy     = 1'b1;
        if (mem_ready) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign word_out = word_q;

endmodule

// File: tb/tb_word_fetch.sv
// Directed bench for word_fetch: one instance per PAGE_WRAP setting, both
// fed from the same stimulus and a small fixed memory image.
module tb_word_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic        ready;

  logic [15:0] addr0, addr1, word0, word1;
  logic        rd0, rd1, busy0, busy1, done0, done1;
  logic [7:0]  data0, data1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h1234: return 8'h78;
      16'h1235: return 8'h56;
      16'h10FF: return 8'h34;
      16'h1100: return 8'h12;
      16'h1000: return 8'hAB;
      16'hFFFF: return 8'hCD;
      16'h0000: return 8'hEF;
      16'hFF00: return 8'h99;
      16'h2000: return 8'h11;
      16'h2001: return 8'h22;
      default:  return 8'h5A;
    endcase
  endfunction

  assign data0 = mem_byte(addr0);
  assign data1 = mem_byte(addr1);

  word_fetch #(.PAGE_WRAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .mem_addr(addr0), .mem_rd(rd0), .mem_data(data0), .mem_ready(ready),
    .word_out(word0), .busy(busy0), .done(done0)
  );

  word_fetch #(.PAGE_WRAP(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .mem_addr(addr1), .mem_rd(rd1), .mem_data(data1), .mem_ready(ready),
    .word_out(word1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check control outputs of dut0 in one go: {busy, mem_rd, done} and address.
  task automatic chk_ctl0(input string tag, input logic [2:0] exp_ctl, input logic [15:0] exp_addr);
    chk({tag, "_ctl"}, {13'd0, busy0, rd0, done0}, {13'd0, exp_ctl});
    chk({tag, "_addr"}, addr0, exp_addr);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = 16'h0000; ready = 1'b0;
    step(); step();
    chk_ctl0("rst", 3'b000, 16'h0000);
    chk("rst_word", word0, 16'h0000);

    // Reset wins over start on the same edge.
    start = 1'b1; base_addr = 16'h1234;
    step();
    chk_ctl0("rst_prio", 3'b000, 16'h0000);
    reset = 1'b1; start = 1'b0;
    // mem_ready in idle must be ignored.
    ready = 1'b1;
    step();
    chk_ctl0("idle_ready", 3'b000, 16'h0000);
    chk("idle_word", word0, 16'h0000);

    // Zero-wait fetch.
    start = 1'b1; base_addr = 16'h1234;
    step();
    start = 1'b0; base_addr = 16'hBEEF;
    chk_ctl0("zw_lo", 3'b110, 16'h1234);
    step();
    chk_ctl0("zw_hi", 3'b110, 16'h1235);
    chk("zw_lo_byte", word0, 16'h0078);
    step();
    chk_ctl0("zw_done", 3'b001, 16'h0000);
    chk("zw_word", word0, 16'h5678);
    step();
    chk_ctl0("zw_idle", 3'b000, 16'h0000);
    chk("zw_hold", word0, 16'h5678);

    // Two wait states per byte.
    ready = 1'b0; start = 1'b1; base_addr = 16'h1234;
    step();
    start = 1'b0;
    step();
    chk_ctl0("ws_lo_w1", 3'b110, 16'h1234);
    step();
    chk_ctl0("ws_lo_w2", 3'b110, 16'h1234);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk_ctl0("ws_hi", 3'b110, 16'h1235);
    step();
    step();
    chk_ctl0("ws_hi_w2", 3'b110, 16'h1235);
    ready = 1'b1;
    step();
    chk_ctl0("ws_done", 3'b001, 16'h0000);
    chk("ws_word", word0, 16'h5678);
    step();

    // Page boundary, both flavours side by side.
    start = 1'b1; base_addr = 16'h10FF;
    step();
    start = 1'b0;
    chk("pg_lo0", addr0, 16'h10FF);
    step();
    chk("pg_hi0", addr0, 16'h1100);
    chk("pg_hi1", addr1, 16'h1000);
    step();
    chk("pg_word0", word0, 16'h1234);
    chk("pg_word1", word1, 16'hAB34);
    chk("pg_done1", {15'd0, done1}, 16'h0001);
    step();

    // Full 16-bit address wrap.
    start = 1'b1; base_addr = 16'hFFFF;
    step();
    start = 1'b0;
    step();
    chk("wr_hi0", addr0, 16'h0000);
    chk("wr_hi1", addr1, 16'hFF00);
    step();
    chk("wr_word0", word0, 16'hEFCD);
    chk("wr_word1", word1, 16'h99CD);
    step();

    // Start while busy is ignored.
    start = 1'b1; base_addr = 16'h1234;
    step();
    start = 1'b0;
    step();
    start = 1'b1; base_addr = 16'h2000;
    chk_ctl0("sb_hi", 3'b110, 16'h1235);
    step();
    start = 1'b0;
    chk_ctl0("sb_done", 3'b001, 16'h0000);
    chk("sb_word", word0, 16'h5678);
    step();
    chk_ctl0("sb_idle", 3'b000, 16'h0000);
    step();
    chk_ctl0("sb_no_restart", 3'b000, 16'h0000);

    // Reset during the high-byte read.
    start = 1'b1; base_addr = 16'h1234;
    step();
    start = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk_ctl0("rm_idle", 3'b000, 16'h0000);
    chk("rm_word", word0, 16'h0000);
    reset = 1'b1;
    step();
    chk_ctl0("rm_no_done", 3'b000, 16'h0000);
    start = 1'b1; base_addr = 16'h2000;
    step();
    start = 1'b0;
    chk_ctl0("rm_lo", 3'b110, 16'h2000);
    step();
    step();
    chk_ctl0("rm_done", 3'b001, 16'h0000);
    chk("rm_word2", word0, 16'h2211);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_fetch.md
WORD_FETCH -- requirements
Module: word_fetch

Interface
REQ-001 SHALL have parameter: PAGE_WRAP, default 0, 1 = high-byte address stays within the page of the low-byte address (6502 indirect-vector behaviour).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset (reset = 0 resets on next rising clk).
REQ-004 SHALL have port: start  input  1  request a 16-bit little-endian fetch; sampled only in IDLE.
REQ-005 SHALL have port: base_addr  input  16  address of low byte; captured when start is accepted.
REQ-006 SHALL have port: mem_addr  output  16  memory read address.
REQ-007 SHALL have port: mem_rd  output  1  read strobe; mem_addr valid while high.
REQ-008 SHALL have port: mem_data  input  8  read data from memory.
REQ-009 SHALL have port: mem_ready  input  1  mem_data valid this cycle; sampled only while mem_rd = 1.
REQ-010 SHALL have port: word_out  output  16  fetched word {hi, lo}.
REQ-011 SHALL have port: busy  output  1  fetch in progress.
REQ-012 SHALL have port: done  output  1  one-cycle pulse; word_out valid.

Function
REQ-013 SHALL implement FSM states IDLE, READ_LO, READ_HI, DONE.
REQ-014 SHALL move IDLE -> READ_LO on an edge with start = 1, capturing base_addr into an internal address register.
REQ-015 SHALL, in READ_LO, drive mem_rd = 1 and mem_addr = captured base.
REQ-016 SHALL, in READ_LO with mem_ready = 1 at an edge, latch mem_data into word_out[7:0] and move to READ_HI; otherwise stay (unbounded wait states).
REQ-017 SHALL, in READ_HI, drive mem_rd = 1 and mem_addr = base + 1 (16-bit, 16'hFFFF wraps to 16'h0000) when PAGE_WRAP = 0, or {base[15:8], base[7:0] + 8'd1} when PAGE_WRAP = 1.
REQ-018 SHALL, in READ_HI with mem_ready = 1 at an edge, latch mem_data into word_out[15:8] and move to DONE.
REQ-019 SHALL, in DONE, drive done = 1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 SHALL drive busy = 1 in READ_LO and READ_HI only; mem_rd = 0 and mem_addr = 16'h0000 in IDLE and DONE.
REQ-021 SHALL ignore start in any state other than IDLE; base_addr changes after capture SHALL have no effect.
REQ-022 SHALL hold word_out stable from DONE until the low-byte latch of the next fetch.
REQ-023 SHALL ignore mem_ready and mem_data when mem_rd = 0.
REQ-024 SHALL have a minimum latency of 3 cycles from start accepted to done (zero wait states): start at edge 0, lo latched at edge 1, hi latched at edge 2, done high in the cycle after edge 2.

Reset
REQ-025 SHALL, on an edge with reset = 0, go to IDLE and clear word_out = 16'h0000, done = 0, busy = 0, mem_rd = 0, mem_addr = 16'h0000, regardless of state (including mid-fetch) and of start and mem_ready.
REQ-026 SHALL give reset priority over start on the same edge.

Structure
REQ-027 SHALL place the FSM state typedef (enum, 2 bits) in the shared CPU package for reuse by the control unit and benches.
REQ-028 SHALL be a single module with no sub-modules.

Verification
REQ-029 Zero-wait fetch: base 16'h1234, mem[1234] = 8'h78, mem[1235] = 8'h56, ready always 1 -> done 3 cycles after start, word_out = 16'h5678.
REQ-030 Wait states: same data, ready low 2 cycles per byte -> mem_addr held at 16'h1234 then 16'h1235 while waiting, done after 7 cycles, word_out = 16'h5678.
REQ-031 Page boundary: base 16'h10FF, mem[10FF] = 8'h34, mem[1100] = 8'h12, mem[1000] = 8'hAB -> PAGE_WRAP = 0 gives 16'h1234; PAGE_WRAP = 1 reads 16'h1000, giving 16'hAB34.
REQ-032 Address wrap: base 16'hFFFF, PAGE_WRAP = 0 -> second read at 16'h0000.
REQ-033 Start while busy: start pulsed in READ_HI with different base_addr -> ignored, original fetch completes, single done pulse.
REQ-034 Reset mid-fetch: reset = 0 during READ_HI -> next cycle IDLE, mem_rd = 0, word_out = 16'h0000, no done; new start afterwards fetches correctly.
